// File: rtl/wb_regfile_if.sv
// MEM->WB handshake: one writeback entry {regW, regAddr, regData} with valid/ready.
interface wb_regfile_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH+ADDR_WIDTH:0] mem_to_wb_bus;
    logic                           mem_to_wb_valid;
    logic                           wb_to_mem_ready;

    modport master (output mem_to_wb_bus, output mem_to_wb_valid, input  wb_to_mem_ready);
    modport slave  (input  mem_to_wb_bus, input  mem_to_wb_valid, output wb_to_mem_ready);
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage: one held entry retiring into the register file, two bypassed
// combinational read ports, and a commit trace plus retire counter.
module wb_regfile_rd #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic [AW-1:0]                addr,
    input  logic [(1<<AW)-1:0][DW-1:0]   rf,
    input  logic                         byp_en,
    input  logic [AW-1:0]                byp_addr,
    input  logic [DW-1:0]                byp_data,
    output logic [DW-1:0]                data
);
    // The held entry wins over the file so decode sees it before it retires.
    always_comb begin
        data = '0;
        if (addr != '0) begin
            if (byp_en && (byp_addr == addr)) data = byp_data;
            else                              data = rf[addr];
        end
    end
endmodule

module wb_regfile #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_regfile_if.slave           mem,
    input  logic                  halt,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    output logic                  commit_valid,
    output logic                  commit_we,
    output logic [ADDR_WIDTH-1:0] commit_addr,
    output logic [DATA_WIDTH-1:0] commit_data,
    output logic [31:0]           retire_cnt
);
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int NUM_RD = 2;

    typedef struct packed {
        logic                  regw;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_ent_t;

    wb_ent_t                          held, incoming;
    logic                             wb_valid, retire, accept;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] rf;

    assign incoming            = wb_ent_t'(mem.mem_to_wb_bus);
    assign retire              = wb_valid & ~halt;
    assign mem.wb_to_mem_ready = ~wb_valid | retire;
    assign accept              = mem.mem_to_wb_valid & mem.wb_to_mem_ready;

    assign commit_valid = retire;
    assign commit_we    = retire & held.regw & (held.addr != '0);
    assign commit_addr  = held.addr;
    assign commit_data  = held.data;

    // Entry 0 is never written (commit_we excludes it), so it stays at its reset 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid   <= 1'b0;
            held       <= '0;
            rf         <= '0;
            retire_cnt <= '0;
        end else begin
            if (accept) begin
                held     <= incoming;
                wb_valid <= 1'b1;
            end else if (retire) begin
                wb_valid <= 1'b0;
            end
            if (commit_we) rf[held.addr] <= held.data;
            if (retire)    retire_cnt    <= retire_cnt + 32'd1;
        end
    end

    logic [NUM_RD-1:0][ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data;

    assign rd_addr  = {rs2_addr, rs1_addr};
    assign rs1_data = rd_data[0];
    assign rs2_data = rd_data[1];

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        wb_regfile_rd #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_rd (
            .addr     (rd_addr[g]),
            .rf       (rf),
            .byp_en   (wb_valid & held.regw),
            .byp_addr (held.addr),
            .byp_data (held.data),
            .data     (rd_data[g])
        );
    end
endmodule

// File: tb/tb_wb_regfile.sv
// Directed vector bench for wb_regfile: per-cycle table plus reset and counter-wrap sequences.
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        halt = 1'b0;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0;
    logic [31:0] rs1_data, rs2_data, commit_data, retire_cnt;
    logic        commit_valid, commit_we;
    logic [4:0]  commit_addr;

    int checks = 0;
    int errors = 0;

    wb_regfile_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) mem_if ();

    wb_regfile #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem          (mem_if),
        .halt         (halt),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .commit_valid (commit_valid),
        .commit_we    (commit_we),
        .commit_addr  (commit_addr),
        .commit_data  (commit_data),
        .retire_cnt   (retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] v, w, a, d, h, r1, r2;
        logic [31:0] e_rdy, e_cv, e_cwe, e_ca, e_cd, e_r1, e_r2, e_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [4:0] a, input logic [31:0] d);
        mem_if.mem_to_wb_valid = v;
        mem_if.mem_to_wb_bus   = {w, a, d};
    endtask

    initial begin
        // v w a d h r1 r2 | rdy cv cwe ca cd r1 r2 cnt
        vq.push_back('{1,1,1,'h11,0,1,2,       1,0,0,0,0,         0,0,0});
        vq.push_back('{1,1,2,'h22,0,1,2,       1,1,1,1,'h11,      'h11,0,0});
        vq.push_back('{1,1,1,'h33,0,1,2,       1,1,1,2,'h22,      'h11,'h22,1});
        vq.push_back('{0,0,0,0,0,1,2,          1,1,1,1,'h33,      'h33,'h22,2});
        vq.push_back('{0,0,0,0,0,1,2,          1,0,0,0,0,         'h33,'h22,3});
        vq.push_back('{1,1,7,'hCAFE,0,7,7,     1,0,0,0,0,         0,0,3});
        vq.push_back('{0,0,0,0,0,7,7,          1,1,1,7,'hCAFE,    'hCAFE,'hCAFE,3});
        vq.push_back('{0,0,0,0,0,7,7,          1,0,0,0,0,         'hCAFE,'hCAFE,4});
        vq.push_back('{1,1,0,'hFFFF,0,0,3,     1,0,0,0,0,         0,0,4});
        vq.push_back('{1,0,3,'h1234,0,0,3,     1,1,0,0,'hFFFF,    0,0,4});
        vq.push_back('{0,0,0,0,0,0,3,          1,1,0,3,'h1234,    0,0,5});
        vq.push_back('{0,0,0,0,0,0,3,          1,0,0,0,0,         0,0,6});
        vq.push_back('{1,1,4,'hAB,1,4,1,       1,0,0,0,0,         0,'h33,6});
        for (int k = 0; k < 5; k++)
            vq.push_back('{1,1,4,'hCD,1,4,1,   0,0,0,0,0,         'hAB,'h33,6});
        vq.push_back('{1,1,4,'hCD,0,4,1,       1,1,1,4,'hAB,      'hAB,'h33,6});
        vq.push_back('{0,0,0,0,0,4,1,          1,1,1,4,'hCD,      'hCD,'h33,7});
        vq.push_back('{0,0,0,0,0,4,1,          1,0,0,0,0,         'hCD,'h33,8});

        drive(1'b0, 1'b0, 5'd0, 32'd0);
        #2;
        chk("rst_ready", 32'(mem_if.wb_to_mem_ready), 32'd1);
        chk("rst_cv",    32'(commit_valid), 32'd0);
        chk("rst_cnt",   retire_cnt, 32'd0);
        chk("rst_rs1",   rs1_data, 32'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        foreach (vq[i]) begin
            drive(vq[i].v[0], vq[i].w[0], vq[i].a[4:0], vq[i].d);
            halt     = vq[i].h[0];
            rs1_addr = vq[i].r1[4:0];
            rs2_addr = vq[i].r2[4:0];
            @(negedge clk);
            chk($sformatf("v%0d_ready", i), 32'(mem_if.wb_to_mem_ready), vq[i].e_rdy);
            chk($sformatf("v%0d_cv", i),    32'(commit_valid), vq[i].e_cv);
            chk($sformatf("v%0d_cwe", i),   32'(commit_we), vq[i].e_cwe);
            chk($sformatf("v%0d_rs1", i),   rs1_data, vq[i].e_r1);
            chk($sformatf("v%0d_rs2", i),   rs2_data, vq[i].e_r2);
            chk($sformatf("v%0d_cnt", i),   retire_cnt, vq[i].e_cnt);
            if (vq[i].e_cv[0]) begin
                chk($sformatf("v%0d_caddr", i), 32'(commit_addr), vq[i].e_ca);
                chk($sformatf("v%0d_cdata", i), commit_data, vq[i].e_cd);
            end
            @(posedge clk); #1;
        end

        // Mid-cycle reset discards a held, halted entry.
        drive(1'b1, 1'b1, 5'd5, 32'hDEAD);
        halt = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd1;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        halt = 1'b1;
        #1;
        chk("mr_ready_held", 32'(mem_if.wb_to_mem_ready), 32'd0);
        chk("mr_bypass",     rs1_data, 32'hDEAD);
        rst = 1'b0;
        #1;
        chk("mr_ready", 32'(mem_if.wb_to_mem_ready), 32'd1);
        chk("mr_cv",    32'(commit_valid), 32'd0);
        chk("mr_rs1",   rs1_data, 32'd0);
        chk("mr_rs2",   rs2_data, 32'd0);
        chk("mr_cnt",   retire_cnt, 32'd0);
        halt = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("mr_post_rs1", rs1_data, 32'd0);
        chk("mr_post_cv",  32'(commit_valid), 32'd0);
        chk("mr_post_cnt", retire_cnt, 32'd0);

        // Counter wrap: preload all-ones, then retire a non-writing entry.
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt;
        #1;
        chk("wrap_pre", retire_cnt, 32'hFFFF_FFFF);
        drive(1'b1, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        chk("wrap_cv",  32'(commit_valid), 32'd1);
        chk("wrap_cwe", 32'(commit_we), 32'd0);
        @(posedge clk); #1;
        chk("wrap_cnt", retire_cnt, 32'd0);
        chk("wrap_idle", 32'(commit_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file. It is the consuming end of the MEM→WB valid/ready handshake, and holds one in-flight writeback entry. It retires that entry into a 2^ADDR_WIDTH-entry register file and serves two combinational read ports to decode, with bypass from the held entry. It also emits a per-retire commit trace and a retire counter for the simulation harness.

## Interface
- ADDR_WIDTH, 5, register index width; file depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 32, register data width.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_to_wb_bus  in  DATA_WIDTH+ADDR_WIDTH+1  {regW, regAddr, regData}:
  - regW at bit [DATA_WIDTH+ADDR_WIDTH];
  - regAddr at [DATA_WIDTH+ADDR_WIDTH-1:DATA_WIDTH];
  - regData at [DATA_WIDTH-1:0].
- mem_to_wb_valid  in  1  upstream entry valid.
- wb_to_mem_ready  out  1  stage can accept this cycle.
- halt  in  1  debug freeze; blocks retirement while high.
- rs1_addr, rs2_addr  in  ADDR_WIDTH each  read indices.
- rs1_data, rs2_data  out  DATA_WIDTH each  read data, combinational.
- commit_valid  out  1  retire pulse.
- commit_we  out  1  retired entry wrote a register (regW=1 and addr≠0).
- commit_addr  out  ADDR_WIDTH  retired entry index.
- commit_data  out  DATA_WIDTH  retired entry data.
- retire_cnt  out  32  retired-entry count.

## Operation
- Holding register: wb_valid, w_regW, w_regAddr, w_regData.
- retire = wb_valid & ~halt.
- wb_to_mem_ready = ~wb_valid | retire (combinational; one entry per cycle sustained).
- Accept when mem_to_wb_valid & wb_to_mem_ready:
  - capture the bus fields;
  - set wb_valid=1.
- Otherwise, if retire: wb_valid ← 0.
- Accept and retire in the same cycle: the new entry replaces the old one; wb_valid stays 1.
- Holding fields update only on accept; they are don't-care while wb_valid=0.
- Register write on retire when w_regW=1 and w_regAddr≠0: file[w_regAddr] ← w_regData.
- Index 0: never written; always reads 0.
- Read port k:
  - rsk_addr=0 → 0.
  - Else if wb_valid & w_regW & w_regAddr==rsk_addr → w_regData. This bypass applies even while halted.
  - Else → file[rsk_addr].
- Commit outputs are combinational from the holding register:
  - commit_valid = retire.
  - commit_we = retire & w_regW & (w_regAddr≠0).
  - commit_addr = w_regAddr; commit_data = w_regData. Both are meaningful only when commit_valid=1.
- retire_cnt increments by 1 on every retire, including regW=0 entries and entries with addr=0.
  - It is 32 bits and wraps 0xFFFFFFFF→0 with no flag.

## Timing
- Reset (rst=0, asynchronous, takes effect immediately without a clock edge):
  - wb_valid=0, hence wb_to_mem_ready=1 and commit_valid=commit_we=0.
  - retire_cnt=0.
  - All file entries 0, so rs1_data/rs2_data read 0.
  - Holding fields reset to 0.
- Reset mid-operation: an un-retired held entry is discarded; no write, no commit pulse.
- Deassertion is sampled normally; the first accept is possible on the first rising edge with rst=1.
- Latency, for an entry accepted at edge N:
  - visible via bypass during cycle N+1;
  - retires at edge N+1 if halt=0 in cycle N+1;
  - readable from the file from cycle N+2.
- Halt:
  - While halt=1 with wb_valid=1: ready=0, entry held, no write, no count.
  - While halt=1 with wb_valid=0: ready=1; one entry is accepted, then the stage stalls.
  - Halt dropping retires the held entry at the next edge.
- Upstream contract: bus and valid are stable while valid=1 and ready=0. The stage does not check this.

## Test plan
- Reset:
  - Stimulus: assert rst=0 mid-cycle with wb_valid=1 holding {1,5,0xDEAD}.
  - Required: wb_valid/ready drop/rise immediately; after release, rs1_addr=5 reads 0; retire_cnt=0; no commit pulse.
- Back-to-back writes:
  - Stimulus: valid held 1 for 3 cycles with {1,1,0x11}, {1,2,0x22}, {1,1,0x33}.
  - Required: ready stays 1; commit_valid high on 3 consecutive cycles; final x1=0x33, x2=0x22; retire_cnt=3.
- Bypass:
  - Stimulus: accept {1,7,0xCAFE} with rs1_addr=rs2_addr=7.
  - Required: rs1_data=rs2_data=0xCAFE in the cycle after accept (file still old); still 0xCAFE from the file afterwards.
- x0 and non-writing entries:
  - Stimulus: accept {1,0,0xFFFF} and {0,3,0x1234}.
  - Required: x0 reads 0; x3 unchanged; commit_valid=1 with commit_we=0 for both; retire_cnt advances by 2.
- Halt:
  - Stimulus: halt=1, then accept {1,4,0xAB}; hold halt 5 cycles with valid=1 and next entry {1,4,0xCD}.
  - Required: ready=0 for those 5 cycles; rs1_addr=4 bypass returns 0xAB; no commit pulses.
  - Then on halt=0: 0xAB retires and 0xCD is accepted on the same edge; 0xCD commits the following cycle.
- Counter wrap:
  - Stimulus: force retire_cnt=0xFFFFFFFF, then retire one entry.
  - Required: retire_cnt=0.
